bit_pattern_tx: RTL and testbench

Serial pattern transmitter that drives the 1-bit `data` line consumed by the team's bit-pattern detector. It accepts parallel words over a valid/ready handshake and serialises them MSB-first, optionally prefixed with the detect pattern as a preamble. Each frame is followed by a zero gap that flushes any downstream detector. A built-in shadow matcher reports when the emitted stream completes the pattern and counts those matches. This gives benches and system logic the exact expected detect count.

---
 rtl/bit_pattern_tx.sv | 193 +++++++++++++++++++
 tb/tb_bit_pattern_tx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_pattern_tx.sv
// -----------------------------------------------------------------------------
// bit_pattern_tx
//
// Serial pattern transmitter for the bit-pattern detector. Parallel words are
// taken over a valid/ready handshake and sent MSB-first on `data`. When
// in_mode=1, PATTERN goes out first as a preamble. Every frame ends with GAP
// zero cycles, which flush any downstream detector.
//
// A shadow matcher watches the emitted stream with the same overlapping,
// same-cycle (Mealy) alignment as the receiving detector. It counts matches
// so that system logic knows the exact detect count to expect.
//
// Parameters
//   WIDTH    payload bits per word (>= 1)
//   PLEN     pattern length in bits (1..8)
//   PATTERN  preamble / match pattern, MSB sent first
//   GAP      zero cycles appended after each frame (>= PLEN)
//
// Ports
//   clk       clock
//   rst_n     synchronous, active-low reset
//   in_valid  word offered
//   in_data   word to serialise
//   in_mode   0 = payload only, 1 = PATTERN preamble then payload
//   in_ready  block can accept a word (IDLE only)
//   clr_cnt   synchronous clear of hit_cnt (wins over an increment)
//   data      serial bit stream (registered)
//   busy      frame or gap in progress
//   done      1-cycle pulse in the first GAP cycle
//   exp_hit   emitted stream completes PATTERN this cycle
//   hit_cnt   number of exp_hit cycles, wraps at 16'hFFFF
// -----------------------------------------------------------------------------
module bit_pattern_tx #(
    parameter int unsigned       WIDTH   = 8,
    parameter int unsigned       PLEN    = 4,
    parameter logic [PLEN-1:0]   PATTERN = 4'b1011,
    parameter int unsigned       GAP     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             in_ready,
    input  logic             clr_cnt,
    output logic             data,
    output logic             busy,
    output logic             done,
    output logic             exp_hit,
    output logic [15:0]      hit_cnt
);

    // One bit-index counter covers the longest of the three phases.
    localparam int unsigned MAX_AB = (PLEN > WIDTH) ? PLEN : WIDTH;
    localparam int unsigned MAX_V  = (MAX_AB > GAP) ? MAX_AB : GAP;
    localparam int unsigned CNT_W  = (MAX_V > 1) ? $clog2(MAX_V) : 1;

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PLEN - 1);
    localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_PAYLOAD,
        S_GAP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;      // cycles left in the current phase, minus one
    logic [WIDTH-1:0] word;     // payload, shifted left as bits go out
    logic [PLEN-1:0]  pat_sh;   // preamble, shifted left as bits go out
    logic [PLEN-1:0]  win;      // last PLEN bits of the stream, newest in LSB

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    // -------------------------------------------------------------------------
    // Frame FSM. `data` is registered: each transition also loads the bit
    // that belongs to the cycle being entered, so the first frame bit appears
    // in the cycle right after the handshake edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout, so every register samples
        // the values from before this edge regardless of statement order.
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            word   <= '0;
            pat_sh <= '0;
            data   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    data <= 1'b0;
                    if (in_valid) begin
                        if (in_mode) begin
                            state  <= S_PRE;
                            cnt    <= PRE_LAST;
                            data   <= PATTERN[PLEN-1];
                            pat_sh <= PATTERN << 1;
                            word   <= in_data;
                        end else begin
                            state <= S_PAYLOAD;
                            cnt   <= PAY_LAST;
                            data  <= in_data[WIDTH-1];
                            word  <= in_data << 1;
                        end
                    end
                end

                S_PRE: begin
                    if (cnt == '0) begin
                        state <= S_PAYLOAD;
                        cnt   <= PAY_LAST;
                        data  <= word[WIDTH-1];
                        word  <= word << 1;
                    end else begin
                        cnt    <= cnt - 1'b1;
                        data   <= pat_sh[PLEN-1];
                        pat_sh <= pat_sh << 1;
                    end
                end

                S_PAYLOAD: begin
                    if (cnt == '0) begin
                        state <= S_GAP;
                        cnt   <= GAP_LAST;
                        data  <= 1'b0;
                        done  <= 1'b1;   // high for the first GAP cycle
                    end else begin
                        cnt  <= cnt - 1'b1;
                        data <= word[WIDTH-1];
                        word <= word << 1;
                    end
                end

                S_GAP: begin
                    data <= 1'b0;
                    if (cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    data  <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Shadow matcher. hist holds the previous PLEN-1 stream bits. It shifts
    // every cycle, including IDLE zeros, so the window lines up with the
    // receiving detector's overlapping match.
    // -------------------------------------------------------------------------
    generate
        if (PLEN > 1) begin : g_hist
            localparam int unsigned HW = PLEN - 1;
            logic [HW-1:0] hist;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    hist <= '0;
                end else begin
                    hist <= HW'({hist, data});
                end
            end

            assign win = {hist, data};
        end else begin : g_no_hist
            assign win = data;
        end
    endgenerate

    assign exp_hit = (win == PATTERN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt <= '0;
        end else if (clr_cnt) begin
            hit_cnt <= '0;
        end else if (exp_hit) begin
            hit_cnt <= hit_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_bit_pattern_tx.sv
// -----------------------------------------------------------------------------
// tb_bit_pattern_tx
//
// Directed bench for bit_pattern_tx. Expected streams and hit positions are
// written out by hand for the default PATTERN 1011 with PLEN=4, WIDTH=8 and
// GAP=4.
//
// A second instance uses PLEN=1 and PATTERN=0. It matches on every idle zero
// cycle, so its hit_cnt can be run all the way up to the 16-bit wrap.
// -----------------------------------------------------------------------------
module tb_bit_pattern_tx;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data  = 8'h00;
    logic        in_mode  = 1'b0;
    logic        clr_cnt  = 1'b0;
    logic        in_ready;
    logic        data;
    logic        busy;
    logic        done;
    logic        exp_hit;
    logic [15:0] hit_cnt;

    logic        rst2_n = 1'b0;
    logic        in_ready2;
    logic        data2;
    logic        busy2;
    logic        done2;
    logic        exp_hit2;
    logic [15:0] hit_cnt2;

    int n_vec = 0;
    int n_err = 0;

    logic        strm [0:47];
    logic [7:0]  words [0:3];

    always #5 clk = ~clk;

    bit_pattern_tx dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_mode  (in_mode),
        .in_ready (in_ready),
        .clr_cnt  (clr_cnt),
        .data     (data),
        .busy     (busy),
        .done     (done),
        .exp_hit  (exp_hit),
        .hit_cnt  (hit_cnt)
    );

    bit_pattern_tx #(
        .WIDTH   (8),
        .PLEN    (1),
        .PATTERN (1'b0),
        .GAP     (4)
    ) dut_wrap (
        .clk      (clk),
        .rst_n    (rst2_n),
        .in_valid (1'b0),
        .in_data  (8'h00),
        .in_mode  (1'b0),
        .in_ready (in_ready2),
        .clr_cnt  (1'b0),
        .data     (data2),
        .busy     (busy2),
        .done     (done2),
        .exp_hit  (exp_hit2),
        .hit_cnt  (hit_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_count();
        clr_cnt = 1'b1;
        step(1);
        clr_cnt = 1'b0;
        check("clr_cnt", 32'(hit_cnt), 0);
    endtask

    // Sends one word and checks every cycle of the frame plus its gap.
    // exp_bits / exp_hits hold cycle t+1 in bit 15.
    task automatic run_frame(input string tag, input logic mode, input logic [7:0] w,
                             input logic [15:0] exp_bits, input logic [15:0] exp_hits,
                             input int nbits);
        logic [15:0] bits_sh = exp_bits;
        logic [15:0] hits_sh = exp_hits;
        logic [15:0] exp_cnt = hit_cnt;
        int          ncyc    = nbits + 4;
        in_mode  = mode;
        in_data  = w;
        in_valid = 1'b1;
        check($sformatf("%s_ready_pre", tag), 32'(in_ready), 1);
        step(1);
        // Free to change once the handshake edge has passed.
        in_valid = 1'b0;
        in_data  = 8'h5A;
        in_mode  = ~mode;
        for (int k = 1; k <= ncyc; k++) begin
            check($sformatf("%s_data_t%0d", tag, k), 32'(data), 32'(bits_sh[15]));
            check($sformatf("%s_hit_t%0d", tag, k), 32'(exp_hit), 32'(hits_sh[15]));
            check($sformatf("%s_done_t%0d", tag, k), 32'(done), 32'(k == nbits + 1));
            check($sformatf("%s_busy_t%0d", tag, k), 32'(busy), 1);
            check($sformatf("%s_cnt_t%0d", tag, k), 32'(hit_cnt), 32'(exp_cnt));
            if (hits_sh[15]) exp_cnt = exp_cnt + 16'd1;
            bits_sh = bits_sh << 1;
            hits_sh = hits_sh << 1;
            step(1);
        end
        check($sformatf("%s_ready_post", tag), 32'(in_ready), 1);
        check($sformatf("%s_busy_post", tag), 32'(busy), 0);
        check($sformatf("%s_cnt_post", tag), 32'(hit_cnt), 32'(exp_cnt));
    endtask

    initial begin : main
        int          hs_at [$];
        logic        rdy_prev;
        logic        seen;
        int          nxt;
        logic [7:0]  pay;
        logic [3:0]  pre;
        int          c0;

        // ---------------- reset ----------------
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        check("rst_data",  32'(data), 0);
        check("rst_ready", 32'(in_ready), 1);
        check("rst_busy",  32'(busy), 0);
        check("rst_cnt",   32'(hit_cnt), 0);
        check("rst_hit",   32'(exp_hit), 0);
        check("rst_done",  32'(done), 0);

        // ---------------- frames ----------------
        run_frame("m0_b6", 1'b0, 8'hB6, 16'b1011_0110_0000_0000, 16'b0001_0010_0000_0000, 8);
        check("m0_b6_total", 32'(hit_cnt), 2);

        clear_count();
        run_frame("m1_00", 1'b1, 8'h00, 16'b1011_0000_0000_0000, 16'b0001_0000_0000_0000, 12);
        check("m1_00_total", 32'(hit_cnt), 1);

        clear_count();
        run_frame("m1_b0", 1'b1, 8'hB0, 16'b1011_1011_0000_0000, 16'b0001_0001_0000_0000, 12);
        check("m1_b0_total", 32'(hit_cnt), 2);

        // ---------------- clr_cnt on a hit edge ----------------
        clear_count();
        in_mode  = 1'b0;
        in_data  = 8'hB6;
        in_valid = 1'b1;
        step(1);                 // cycle t+1
        in_valid = 1'b0;
        step(3);                 // cycle t+4
        check("clr_hit_t4", 32'(exp_hit), 1);
        clr_cnt = 1'b1;
        step(1);                 // cycle t+5
        clr_cnt = 1'b0;
        check("clr_wins", 32'(hit_cnt), 0);
        step(2);                 // cycle t+7
        check("clr_hit_t7", 32'(exp_hit), 1);
        check("clr_cnt_t7", 32'(hit_cnt), 0);
        step(1);                 // cycle t+8
        check("clr_cnt_t8", 32'(hit_cnt), 1);
        step(5);                 // cycle t+13
        check("clr_ready_t13", 32'(in_ready), 1);

        // ---------------- reset mid-payload ----------------
        clear_count();
        in_mode  = 1'b1;
        in_data  = 8'hB0;
        in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        step(5);                 // cycle t+6, inside the payload
        check("mid_busy", 32'(busy), 1);
        check("mid_cnt",  32'(hit_cnt), 1);
        rst_n = 1'b0;
        step(1);
        check("mid_rst_busy",  32'(busy), 0);
        check("mid_rst_ready", 32'(in_ready), 1);
        check("mid_rst_data",  32'(data), 0);
        check("mid_rst_cnt",   32'(hit_cnt), 0);
        check("mid_rst_done",  32'(done), 0);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step(1);
            seen = seen | data | busy;
        end
        check("mid_dropped", 32'(seen), 0);

        // ---------------- back-to-back throughput ----------------
        words[0] = 8'hA5;
        words[1] = 8'h3C;
        words[2] = 8'h0F;
        words[3] = 8'h00;
        nxt      = 1;
        rdy_prev = 1'b0;
        in_mode  = 1'b1;
        in_data  = words[0];
        in_valid = 1'b1;
        for (int c = 0; c < 48; c++) begin
            strm[c] = data;
            if (rdy_prev && nxt < 4) begin
                in_data = words[nxt];
                nxt++;
            end
            rdy_prev = in_ready;
            if (in_ready) hs_at.push_back(c);
            step(1);
        end
        in_valid = 1'b0;
        check("tp_handshakes", 32'(hs_at.size()), 3);
        if (hs_at.size() >= 3) begin
            check("tp_first",   32'(hs_at[0]), 0);
            check("tp_space_1", 32'(hs_at[1] - hs_at[0]), 17);
            check("tp_space_2", 32'(hs_at[2] - hs_at[1]), 17);
            for (int f = 0; f < 3; f++) begin
                c0 = hs_at[f];
                if (c0 + 12 < 48) begin
                    for (int b = 0; b < 4; b++) pre = {pre[2:0], strm[c0 + 1 + b]};
                    for (int b = 0; b < 8; b++) pay = {pay[6:0], strm[c0 + 5 + b]};
                    check($sformatf("tp_pre_%0d", f), 32'(pre), 32'hB);
                    check($sformatf("tp_word_%0d", f), 32'(pay), 32'(words[f]));
                end
            end
        end
        for (int k = 0; k < 40 && !in_ready; k++) step(1);
        check("tp_idle", 32'(in_ready), 1);

        // ---------------- hit_cnt wrap ----------------
        rst2_n = 1'b1;
        step(1);
        check("wrap_hit",   32'(exp_hit2), 1);
        check("wrap_first", 32'(hit_cnt2), 1);
        step(65534);
        check("wrap_max", 32'(hit_cnt2), 32'hFFFF);
        step(1);
        check("wrap_zero", 32'(hit_cnt2), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
